// File: rtl/coord_collector_pmem.sv
// coord_collector_pmem
//   Coordinate-entry engine for the pathfinding accelerator's initialisation
//   phase. Coordinates arrive one half at a time (X, then Y) on coord_in,
//   qualified by a one-cycle transition strobe. Each completed pair is packed
//   as {Y, X} and written to node memory at consecutive addresses starting at
//   0. A capacity guard flags requests for more pairs once the table is full,
//   and clear (from FINISH) restarts entry from address 0.
//
//   Optional feature: define COORD_RANGE_CHECK_EN to reject coordinates
//   >= GRID_DIM (the FSM holds its state and sets sticky range_err).
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   coord_in        coordinate value being entered
//   transition      one-cycle strobe, coord_in valid
//   enter_new_coord request another pair after a write
//   finish_init     end of coordinate entry
//   clear           from FINISH: empty the table and restart entry
//   mem_we          node-memory write enable (one cycle per pair)
//   mem_addr        node-memory write address
//   mem_wdata       packed pair {Y, X}, X in the low COORD_W bits
//   node_count      number of pairs written (saturates at MAX_NODES)
//   busy            high in every state except FINISH
//   overflow        sticky: new pair requested while the table was full
//   range_err       sticky: out-of-range coordinate seen (feature only)
//   done            high in FINISH
module coord_collector_pmem #(
  parameter int COORD_W   = 8,
  parameter int MAX_NODES = 64,
  parameter int GRID_DIM  = 256,
  localparam int ADDR_W   = $clog2(MAX_NODES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COORD_W-1:0]     coord_in,
  input  logic                   transition,
  input  logic                   enter_new_coord,
  input  logic                   finish_init,
  input  logic                   clear,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [2*COORD_W-1:0]   mem_wdata,
  output logic [ADDR_W:0]        node_count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   range_err,
  output logic                   done
);

  typedef enum logic [2:0] {
    GET_X,
    GET_Y,
    WRITE,
    HOLD,
    FINISH
  } state_t;

  localparam logic [ADDR_W:0]  MAX_CNT  = (ADDR_W+1)'(MAX_NODES);
  localparam logic [COORD_W:0] GRID_LIM = (COORD_W+1)'(GRID_DIM);

`ifdef COORD_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t             state;
  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic               coord_ok;
  logic               table_full;

  // With range checking disabled this folds to constant 1.
  assign coord_ok   = !RANGE_CHECK || ({1'b0, coord_in} < GRID_LIM);
  assign table_full = (node_count == MAX_CNT);

`ifndef COORD_RANGE_CHECK_EN
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= GET_X;
      x_reg      <= '0;
      y_reg      <= '0;
      node_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      overflow   <= 1'b0;
`ifdef COORD_RANGE_CHECK_EN
      range_err  <= 1'b0;
`endif
      done       <= 1'b0;
      busy       <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      case (state)
        GET_X: begin
          if (transition) begin
            if (coord_ok) begin
              x_reg <= coord_in;
              state <= GET_Y;
            end else begin
`ifdef COORD_RANGE_CHECK_EN
              range_err <= 1'b1;
`endif
            end
          end else if (finish_init) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        GET_Y: begin
          // Write strobe and payload are registered here so mem_we is high
          // for exactly the cycle the FSM spends in WRITE.
          if (transition) begin
            if (coord_ok) begin
              y_reg     <= coord_in;
              mem_we    <= 1'b1;
              mem_addr  <= node_count[ADDR_W-1:0];
              mem_wdata <= {coord_in, x_reg};
              state     <= WRITE;
            end else begin
`ifdef COORD_RANGE_CHECK_EN
              range_err <= 1'b1;
`endif
            end
          end
        end

        WRITE: begin
          if (!table_full) begin
            node_count <= node_count + 1'b1;
          end
          state <= HOLD;
        end

        HOLD: begin
          if (finish_init) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (enter_new_coord) begin
            if (table_full) begin
              overflow <= 1'b1;
            end else begin
              state <= GET_X;
            end
          end
        end

        FINISH: begin
          if (clear) begin
            node_count <= '0;
            overflow   <= 1'b0;
`ifdef COORD_RANGE_CHECK_EN
            range_err  <= 1'b0;
`endif
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= GET_X;
          end
        end

        default: begin
          state <= GET_X;
        end
      endcase
    end
  end

  // y_reg mirrors the latched Y half; it is observed through mem_wdata.
  logic unused_y;
  assign unused_y = ^y_reg;

endmodule

// File: tb/tb_coord_collector_pmem.sv
module tb_coord_collector_pmem;
  localparam int CW = 8;
  localparam int MN = 4;
  localparam int GD = 16;
  localparam int AW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [CW-1:0]     coord_in = '0;
  logic              transition = 1'b0;
  logic              enter_new_coord = 1'b0;
  logic              finish_init = 1'b0;
  logic              clear = 1'b0;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [2*CW-1:0]   mem_wdata;
  logic [AW:0]       node_count;
  logic              busy;
  logic              overflow;
  logic              range_err;
  logic              done;

  coord_collector_pmem #(
    .COORD_W  (CW),
    .MAX_NODES(MN),
    .GRID_DIM (GD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .coord_in       (coord_in),
    .transition     (transition),
    .enter_new_coord(enter_new_coord),
    .finish_init    (finish_init),
    .clear          (clear),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .node_count     (node_count),
    .busy           (busy),
    .overflow       (overflow),
    .range_err      (range_err),
    .done           (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  // Reference model: abstract table state
  int exp_cnt = 0;
  int exp_wr = 0;
  bit exp_ovf = 0;
  bit exp_rerr = 0;
  bit exp_done = 0;

  always @(negedge clk) if (mem_we === 1'b1) wr_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  localparam int P_FIN = 0, P_ENT = 1, P_CLR = 2;

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      P_FIN:   finish_init = 1'b1;
      P_ENT:   enter_new_coord = 1'b1;
      default: clear = 1'b1;
    endcase
    @(negedge clk);
    finish_init = 1'b0;
    enter_new_coord = 1'b0;
    clear = 1'b0;
  endtask

  task automatic strobe(input logic [CW-1:0] v);
    @(negedge clk);
    coord_in = v;
    transition = 1'b1;
    @(negedge clk);
    transition = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".node_count"}, 32'(node_count), 32'(exp_cnt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ".range_err"}, 32'(range_err), 32'(exp_rerr));
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
    chk({tag, ".busy"}, 32'(busy), 32'(!exp_done));
    chk({tag, ".writes"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  task automatic put_coord(input logic [CW-1:0] v, output logic [CW-1:0] acc);
    strobe(v);
    acc = v;
`ifdef COORD_RANGE_CHECK_EN
    if (int'(v) >= GD) begin
      exp_rerr = 1;
      chk("reject.range_err", 32'(range_err), 32'd1);
      chk("reject.no_write", 32'(mem_we), 32'd0);
      acc = CW'(int'(v) % GD);
      strobe(acc);
    end
`endif
  endtask

  // Called at the negedge right after the accepted Y strobe was sampled.
  task automatic check_write(input string tag, input logic [CW-1:0] ax, input logic [CW-1:0] ay);
    int data;
    data = int'(ay) * (1 << CW) + int'(ax);
    chk({tag, ".we"}, 32'(mem_we), 32'd1);
    chk({tag, ".addr"}, 32'(mem_addr), 32'(exp_cnt));
    chk({tag, ".wdata"}, 32'(mem_wdata), 32'(data));
    exp_wr++;
    @(negedge clk);
    chk({tag, ".we_low"}, 32'(mem_we), 32'd0);
    if (exp_cnt < MN) exp_cnt++;
    chk({tag, ".count"}, 32'(node_count), 32'(exp_cnt));
  endtask

  task automatic do_pair(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW-1:0] ax, ay;
    put_coord(x, ax);
    put_coord(y, ay);
    check_write(tag, ax, ay);
  endtask

  task automatic clear_table();
    pulse(P_CLR);
    exp_cnt = 0;
    exp_ovf = 0;
    exp_rerr = 0;
    exp_done = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", 32'(mem_addr), 32'd0);
    chk("rst.wdata", 32'(mem_wdata), 32'd0);
    check_status("rst");
    reset = 1'b1;

    // Single pair then finish
    do_pair("p1", 8'h12, 8'h34);
    pulse(P_FIN);
    exp_done = 1;
    check_status("fin1");

    // Three consecutive pairs
    clear_table();
    check_status("clr1");
    do_pair("p3a", 8'h01, 8'h02);
    pulse(P_ENT);
    do_pair("p3b", 8'h03, 8'h04);
    pulse(P_ENT);
    do_pair("p3c", 8'h05, 8'h06);
    check_status("hold3");
    pulse(P_FIN);
    exp_done = 1;
    check_status("fin3");

    // Fill to capacity, then request another pair
    clear_table();
    for (int i = 0; i < MN; i++) begin
      do_pair("fill", CW'(8'h10 + i), CW'(8'h20 + i));
      if (i < MN - 1) pulse(P_ENT);
    end
    pulse(P_ENT);
    exp_ovf = 1;
    check_status("ovf");
    strobe(8'h55);
    strobe(8'h66);
    check_status("ovf_ignore_strobe");
    pulse(P_FIN);
    exp_done = 1;
    check_status("ovf_fin");

    // Clear resets overflow, rewrite from address 0
    clear_table();
    check_status("clr_ovf");
    do_pair("after_clr", 8'hAA, 8'hBB);
    pulse(P_FIN);
    exp_done = 1;
    check_status("fin_aa");

    // Strobes in FINISH are ignored
    strobe(8'h77);
    pulse(P_ENT);
    strobe(8'h78);
    check_status("finish_ignore");

    // Asynchronous reset while in GET_Y discards the partial pair
    clear_table();
    do_pair("pre_rst", 8'h01, 8'h01);
    pulse(P_ENT);
    strobe(8'h07);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_cnt = 0;
    exp_ovf = 0;
    exp_rerr = 0;
    exp_done = 0;
    chk("arst.count", 32'(node_count), 32'd0);
    chk("arst.busy", 32'(busy), 32'd1);
    chk("arst.we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_pair("post_rst", 8'h09, 8'h0A);

    // transition wins over finish_init in GET_X; finish_init ignored in GET_Y
    pulse(P_ENT);
    @(negedge clk);
    coord_in = 8'h01;
    transition = 1'b1;
    finish_init = 1'b1;
    @(negedge clk);
    transition = 1'b0;
    finish_init = 1'b0;
    check_status("tr_wins");
    pulse(P_FIN);
    check_status("getY_fin_ignored");
    strobe(8'h03);
    check_write("tr_pair", 8'h01, 8'h03);
    // finish_init has priority over enter_new_coord in HOLD
    @(negedge clk);
    finish_init = 1'b1;
    enter_new_coord = 1'b1;
    @(negedge clk);
    finish_init = 1'b0;
    enter_new_coord = 1'b0;
    exp_done = 1;
    check_status("fin_prio");

    // Range checking
    clear_table();
`ifdef COORD_RANGE_CHECK_EN
    strobe(8'd20);
    exp_rerr = 1;
    check_status("range_x");
    do_pair("range_pair", 8'h05, 8'h06);
    check_status("range_sticky");
`else
    do_pair("wide_pair", 8'd20, 8'h06);
    check_status("no_range_chk");
`endif
    pulse(P_FIN);
    exp_done = 1;
    check_status("range_fin");

    // Randomized rounds against the table model
    for (int r = 0; r < 8; r++) begin
      int n;
      clear_table();
      n = $urandom_range(1, MN);
      for (int i = 0; i < n; i++) begin
        do_pair("rnd", CW'($urandom_range(0, 255)), CW'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (i < n - 1) pulse(P_ENT);
      end
      if (n == MN && $urandom_range(0, 1) == 1) begin
        pulse(P_ENT);
        exp_ovf = 1;
      end
      check_status("rnd_hold");
      pulse(P_FIN);
      exp_done = 1;
      check_status("rnd_fin");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
